// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: sequencer for a running-max pooling accumulator.
// Optional macro MAXPOOL_CTRL_RELU_EN clamps captured results at zero.
`ifndef DW
`define DW 16
`endif

module maxpool_ctrl #(
  parameter int POOL_SIZE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic signed [`DW-1:0] i_data,
  output logic                  o_ready,
  input  logic                  i_flush,
  output logic                  o_clean,
  output logic                  o_read_clean,
  output logic signed [`DW-1:0] o_mp_din,
  input  logic signed [`DW-1:0] i_mp_dout,
  output logic                  o_valid,
  output logic signed [`DW-1:0] o_data,
  input  logic                  i_ready
);

  localparam int DW = `DW;
  localparam int CW = $clog2(POOL_SIZE);
  localparam logic [CW-1:0] LAST = CW'(POOL_SIZE - 1);
  localparam logic signed [DW-1:0] NEG_MAX =
    {1'b1, {(DW-1){1'b0}}};

  logic [CW-1:0]        cnt;
  logic                 pending;
  logic                 accept;
  logic                 first;
  logic                 last;
  logic                 capture;
  logic signed [DW-1:0] cap_val;

  // Ready is gated by reset directly so it is low for the whole reset.
  always_comb begin
    o_ready = i_rst_n && !i_flush &&
              (!pending || !o_valid || i_ready);
    accept  = i_valid && o_ready;
    first   = accept && (cnt == '0);
    last    = accept && (cnt == LAST);
    capture = pending && !i_flush &&
              (!o_valid || i_ready);
  end

  // Idle cycles feed the most negative value so the max is undisturbed.
  always_comb begin
    o_clean      = i_rst_n && (i_flush || first);
    o_read_clean = i_rst_n && i_flush;
    o_mp_din     = accept ? i_data : NEG_MAX;
  end

`ifdef MAXPOOL_CTRL_RELU_EN
  always_comb begin
    cap_val = i_mp_dout[DW-1] ? '0 : i_mp_dout;
  end
`else
  always_comb begin
    cap_val = i_mp_dout;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= 1'b0;
    end else if (i_flush) begin
      pending <= 1'b0;
    end else if (last) begin
      pending <= 1'b1;
    end else if (capture) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (capture) begin
        o_valid <= 1'b1;
        o_data  <= cap_val;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb_maxpool_ctrl: maxpool_ctrl paired with an accumulator model,
// checked against a window-level reference model.
`ifndef DW
`define DW 16
`endif

module tb_maxpool_ctrl;

  localparam int DW = `DW;
  localparam int PS = 4;
  localparam logic signed [DW-1:0] NEG_MAX =
    {1'b1, {(DW-1){1'b0}}};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 i_flush = 1'b0;
  logic                 i_ready = 1'b1;
  logic signed [DW-1:0] i_data = '0;
  logic                 o_ready;
  logic                 o_clean;
  logic                 o_read_clean;
  logic                 o_valid;
  logic signed [DW-1:0] o_mp_din;
  logic signed [DW-1:0] o_data;
  logic signed [DW-1:0] mp_dout;

  int nchk = 0;
  int nerr = 0;
  int nxfer = 0;

  always #5 clk = ~clk;

  maxpool_ctrl #(.POOL_SIZE(PS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .o_clean     (o_clean),
    .o_read_clean(o_read_clean),
    .o_mp_din    (o_mp_din),
    .i_mp_dout   (mp_dout),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .i_ready     (i_ready)
  );

  // Accumulator: clean loads din, clean+read_clean zeroes, else max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mp_dout <= '0;
    end else if (o_clean && o_read_clean) begin
      mp_dout <= '0;
    end else if (o_clean) begin
      mp_dout <= o_mp_din;
    end else if (o_mp_din > mp_dout) begin
      mp_dout <= o_mp_din;
    end
  end

  task automatic chk(input string name,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: windows of samples, a pending result, output fifo.
  logic signed [DW-1:0] win_q[$];
  logic signed [DW-1:0] exp_q[$];
  logic                 pend_v = 1'b0;
  logic signed [DW-1:0] pend_d = '0;
  logic signed [DW-1:0] last_res = '0;
  logic                 prev_v = 1'b0;
  logic signed [DW-1:0] prev_d = '0;
  logic                 m_vld;
  logic                 m_rdy;
  logic                 m_acc;
  logic signed [DW-1:0] m_max;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 0);
      chk("rst_clean", o_clean, 0);
      chk("rst_read_clean", o_read_clean, 0);
      chk("rst_mp_din", o_mp_din, NEG_MAX);
      chk("rst_data", o_data, 0);
      win_q.delete();
      exp_q.delete();
      pend_v = 1'b0;
      prev_v = 1'b0;
    end else begin
      m_vld = (exp_q.size() != 0);
      m_rdy = !i_flush && (!pend_v || !m_vld || i_ready);
      m_acc = i_valid && m_rdy;
      chk("valid", o_valid, m_vld);
      chk("ready", o_ready, m_rdy);
      chk("clean", o_clean,
          i_flush || (m_acc && win_q.size() == 0));
      chk("read_clean", o_read_clean, i_flush);
      chk("mp_din", o_mp_din, m_acc ? i_data : NEG_MAX);
      if (prev_v) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_data", o_data, prev_d);
      end
      if (pend_v && !i_flush && (!m_vld || i_ready)) begin
        exp_q.push_back(pend_d);
        pend_v = 1'b0;
      end
      if (m_vld && i_ready) begin
        nxfer++;
        chk("data", o_data, exp_q.pop_front());
      end
      prev_v = o_valid && !i_ready;
      prev_d = o_data;
      if (i_flush) begin
        win_q.delete();
        pend_v = 1'b0;
      end else if (m_acc) begin
        win_q.push_back(i_data);
        if (win_q.size() == PS) begin
          m_max = win_q[0];
          foreach (win_q[k]) if (win_q[k] > m_max) m_max = win_q[k];
`ifdef MAXPOOL_CTRL_RELU_EN
          if (m_max < 0) m_max = '0;
`endif
          pend_d   = m_max;
          pend_v   = 1'b1;
          last_res = m_max;
          win_q.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_flush = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int v);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_data  = DW'(v);
    @(negedge clk);
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: o_ready stuck low, sample %0d", v);
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int expv);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid) begin
      nchk++;
      nerr++;
      $display("FAIL %s: no result, expected %0d", name, expv);
    end else begin
      chk(name, o_data, expv);
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("init_valid", o_valid, 0);
    chk("init_data", o_data, 0);
    chk("init_mp_din", o_mp_din, NEG_MAX);
    chk("init_ready", o_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Back-to-back window, latency of two cycles
    send(3); send(-7); send(12); send(5);
    @(negedge clk);
    chk("t1_lat1_valid", o_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_lat2_valid", o_valid, 1);
    chk("t1_data", o_data, 12);
    tick();
    @(negedge clk);
    chk("t1_pulse_end", o_valid, 0);
    chk("t1_model", last_res, 12);
    idle(3);

    // All-negative window
    send(-5); send(-3); send(-9); send(-4);
`ifdef MAXPOOL_CTRL_RELU_EN
    wait_result("t2_data", 0);
    chk("t2_model", last_res, 0);
`else
    wait_result("t2_data", -3);
    chk("t2_model", last_res, -3);
`endif
    idle(3);

    // Backpressure across two windows
    i_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    send(8); send(7); send(6); send(5);
    @(negedge clk);
    chk("t3_ready_drop", o_ready, 0);
    chk("t3_valid", o_valid, 1);
    chk("t3_held", o_data, 4);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("t3_still_held", o_data, 4);
    end
    tick();
    i_ready = 1'b1;
    @(negedge clk);
    chk("t3_first", o_data, 4);
    tick();
    @(negedge clk);
    chk("t3_second_valid", o_valid, 1);
    chk("t3_second", o_data, 8);
    tick();
    @(negedge clk);
    chk("t3_drained", o_valid, 0);
    idle(3);

    // Flush mid-window
    send(9); send(10);
    i_flush = 1'b1;
    @(negedge clk);
    chk("t4_read_clean_on", o_read_clean, 1);
    chk("t4_clean_on", o_clean, 1);
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    chk("t4_read_clean_off", o_read_clean, 0);
    tick();
    send(-2); send(-1); send(-6); send(-8);
`ifdef MAXPOOL_CTRL_RELU_EN
    wait_result("t4_data", 0);
`else
    wait_result("t4_data", -1);
`endif
    idle(3);

    // Reset mid-window
    send(7); send(7);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_rst_valid", o_valid, 0);
      chk("t5_rst_ready", o_ready, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    x0 = nxfer;
    send(1); send(1); send(1); send(1);
    wait_result("t5_data", 1);
    idle(10);
    chk("t5_single", nxfer - x0, 1);

    // Randomized traffic with backpressure, flushes and one reset
    for (int k = 0; k < 600; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       i_data = NEG_MAX;
        1:       i_data = {1'b0, {(DW-1){1'b1}}};
        default: i_data = DW'($urandom);
      endcase
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 24) == 0);
      if (k == 300) rst_n = 1'b0;
      if (k == 302) rst_n = 1'b1;
      tick();
    end

    i_ready = 1'b1;
    idle(20);
    chk("final_pending", pend_v, 0);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
